// File: rtl/ysyx_25040129_ifu_fetch.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_ifu_fetch
//
// Instruction fetch stage. Owns the PC, issues one-word AXI-Lite reads to the
// ICACHE and holds the returned instruction for the decode stage under a
// valid/ready handshake. Redirects from EXU (branch/jump/trap) replace the PC
// and squash any in-flight fetch; fence.i is forwarded to the ICACHE and
// keeps the next request back for one idle cycle.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   redirect_valid, redirect_pc       one-cycle redirect pulse and target
//   fence_i_in                        fence.i pulse (coincides with redirect)
//   ifu_araddr/arvalid/arready        AR channel to ICACHE
//   ifu_rdata/rresp/rvalid/rready     R channel from ICACHE
//   fence_i                           flush request to ICACHE
//   inst_valid/inst_ready             handshake to IDU
//   inst, inst_pc, inst_fault         instruction, its PC, access fault flag
// ----------------------------------------------------------------------------
module ysyx_25040129_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fence_i_in,
    output logic [31:0] ifu_araddr,
    output logic        ifu_arvalid,
    input  logic        ifu_arready,
    input  logic [31:0] ifu_rdata,
    input  logic [1:0]  ifu_rresp,
    input  logic        ifu_rvalid,
    output logic        ifu_rready,
    output logic        fence_i,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault
);

    localparam logic [1:0] StReq   = 2'd0;
    localparam logic [1:0] StWaitR = 2'd1;
    localparam logic [1:0] StOut   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        fence_pend_q, fence_pend_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_fault_q, inst_fault_d;
    logic        ar_hs;

    // Outputs are held low while reset is asserted.
    assign ifu_arvalid = !rst && (state_q == StReq) && !redirect_valid && !fence_pend_q;
    assign ifu_rready  = !rst && (state_q != StOut);
    assign ifu_araddr  = pc_q;
    assign fence_i     = fence_i_in;
    assign inst_valid  = !rst && (state_q == StOut);
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_fault  = inst_fault_q;

    assign ar_hs = ifu_arvalid && ifu_arready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        fence_pend_d = fence_pend_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;

        unique case (state_q)
            StReq: begin
                if (ar_hs) begin
                    if (ifu_rvalid) begin
                        // Cache hit: data arrives with the address handshake.
                        inst_d       = ifu_rdata;
                        inst_pc_d    = pc_q;
                        inst_fault_d = (ifu_rresp != 2'b00);
                        state_d      = StOut;
                    end else begin
                        state_d = StWaitR;
                    end
                end
            end
            StWaitR: begin
                if (ifu_rvalid) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect_valid) begin
                        state_d = StReq;
                    end else begin
                        inst_d       = ifu_rdata;
                        inst_pc_d    = pc_q;
                        inst_fault_d = (ifu_rresp != 2'b00);
                        state_d      = StOut;
                    end
                end else if (redirect_valid) begin
                    // Response still owed by the cache; swallow it when it lands.
                    drop_d = 1'b1;
                end
            end
            StOut: begin
                if (redirect_valid) begin
                    state_d = StReq;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end

        // fence_pend survives until one full non-redirect cycle spent in REQ,
        // giving the cache an idle cycle to invalidate.
        if (fence_i_in) begin
            fence_pend_d = 1'b1;
        end else if (state_q == StReq && !redirect_valid) begin
            fence_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            fence_pend_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            fence_pend_q <= fence_pend_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

endmodule
